// File: rtl/plb_adc_capture.sv
// plb_adc_capture: parallel ADC sample clock generator, capture FSM,
// sample FIFO and single-word read handshake, all in the SPLB_Clk domain.
module plb_adc_capture #(
    parameter int ADC_WIDTH       = 10,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int ADC_LATENCY     = 5
) (
    input  logic                       SPLB_Clk,
    input  logic                       SPLB_Rst_n,
    input  logic [0:ADC_WIDTH-1]       S_ADC_Data,
    input  logic                       S_ADC_OTR,
    output logic                       S_ADC_Clk,
    output logic                       S_ADC_PWRDN,
    input  logic                       Ctrl_En,
    input  logic [0:7]                 Ctrl_ClkDiv,
    input  logic [0:15]                Ctrl_Count,
    input  logic                       Ctrl_Start,
    input  logic                       Ctrl_Stop,
    input  logic                       Ovf_Clr,
    input  logic                       Rd_Req,
    output logic                       Rd_Ack,
    output logic [0:31]                Rd_Data,
    output logic [0:FIFO_DEPTH_LOG2]   Fifo_Level,
    output logic                       Overflow,
    output logic                       Busy,
    output logic                       Done
);

    localparam int L  = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 2 ** L;
    localparam logic [L:0]   FULL_LVL = {1'b1, {L{1'b0}}};
    localparam logic [L:0]   LVL_ONE  = {{L{1'b0}}, 1'b1};
    localparam logic [L-1:0] PTR_ONE  = {{(L-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FLUSH, CAPTURE, DONE} state_e;

    logic             adc_clk_q, adc_clk_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [7:0]       div_val;
    logic             pwrdn_q;
    logic             strobe, strobe_q;
    logic [ADC_WIDTH:0] cap_q;

    state_e           state_q, state_d;
    logic [15:0]      disc_q, disc_d;
    logic [15:0]      smp_q, smp_d;
    logic             push_req;

    logic [ADC_WIDTH:0] mem [DEPTH];
    logic [L-1:0]     wr_ptr_q, rd_ptr_q;
    logic [L:0]       level_q, level_d;
    logic             pop, push, drop, full;
    logic             ovf_q, ovf_d;
    logic             rd_ack_q;
    logic [31:0]      rd_data_q, rd_data_d;
    logic [ADC_WIDTH:0] head;

    // Divider: counts down, toggles the ADC clock at zero, strobes on the fall
    always_comb begin
        div_val   = (Ctrl_ClkDiv == 8'd0) ? 8'd1 : Ctrl_ClkDiv;
        adc_clk_d = adc_clk_q;
        div_cnt_d = div_cnt_q;
        strobe    = 1'b0;
        if (!Ctrl_En) begin
            adc_clk_d = 1'b0;
            div_cnt_d = 8'd0;
        end else if (div_cnt_q == 8'd0) begin
            adc_clk_d = ~adc_clk_q;
            div_cnt_d = div_val - 8'd1;
            strobe    = adc_clk_q;
        end else begin
            div_cnt_d = div_cnt_q - 8'd1;
        end
    end

    // Clock generator, power-down and sample capture registers
    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            adc_clk_q <= 1'b0;
            div_cnt_q <= 8'd0;
            pwrdn_q   <= 1'b1;
            strobe_q  <= 1'b0;
            cap_q     <= '0;
        end else begin
            adc_clk_q <= adc_clk_d;
            div_cnt_q <= div_cnt_d;
            pwrdn_q   <= ~Ctrl_En;
            strobe_q  <= strobe;
            if (strobe) begin
                cap_q <= {S_ADC_OTR, S_ADC_Data};
            end
        end
    end

    // Capture FSM next state; acts on the registered strobe
    always_comb begin
        state_d  = state_q;
        disc_d   = disc_q;
        smp_d    = smp_q;
        push_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Ctrl_Start && Ctrl_En) begin
                    smp_d   = 16'd0;
                    disc_d  = ADC_LATENCY[15:0];
                    state_d = (ADC_LATENCY == 0) ? CAPTURE : FLUSH;
                end
            end
            FLUSH: begin
                if (Ctrl_Stop || !Ctrl_En) begin
                    state_d = DONE;
                end else if (strobe_q) begin
                    disc_d = disc_q - 16'd1;
                    if (disc_d == 16'd0) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (Ctrl_Stop || !Ctrl_En) begin
                    state_d = DONE;
                end else if (strobe_q) begin
                    push_req = 1'b1;
                    smp_d    = smp_q + 16'd1;
                    if (Ctrl_Count != 16'd0 && smp_d == Ctrl_Count) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture FSM state and counters
    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            state_q <= IDLE;
            disc_q  <= 16'd0;
            smp_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            disc_q  <= disc_d;
            smp_q   <= smp_d;
        end
    end

    // FIFO control: a pop frees the slot a same-cycle push on full needs
    always_comb begin
        full  = (level_q == FULL_LVL);
        pop   = Rd_Req && (level_q != '0);
        push  = push_req && (!full || pop);
        drop  = push_req && full && !pop;
        head  = mem[rd_ptr_q];
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        ovf_d = drop ? 1'b1 : (Ovf_Clr ? 1'b0 : ovf_q);
        rd_data_d = '0;
        if (pop) begin
            rd_data_d = {1'b1, head[ADC_WIDTH],
                         {(30 - ADC_WIDTH){1'b0}}, head[ADC_WIDTH-1:0]};
        end
    end

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge SPLB_Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= cap_q;
        end
    end

    // FIFO pointers, level, overflow flag and read response
    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            rd_ack_q  <= Rd_Req;
            rd_data_q <= rd_data_d;
        end
    end

    assign S_ADC_Clk   = adc_clk_q;
    assign S_ADC_PWRDN = pwrdn_q;
    assign Rd_Ack      = rd_ack_q;
    assign Rd_Data     = rd_data_q;
    assign Fifo_Level  = level_q;
    assign Overflow    = ovf_q;
    assign Busy        = (state_q == FLUSH) || (state_q == CAPTURE);
    assign Done        = (state_q == DONE);

endmodule
